// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO family: pointer-width helper and
// error-flag bit positions used by status registers.
package fifo_pkg;

    localparam int ERR_OVERFLOW_BIT  = 0;
    localparam int ERR_UNDERFLOW_BIT = 1;
    localparam int ERR_FLAG_W        = 2;

    // Depths below 2 would give a zero-width pointer; clamp to one bit.
    function automatic int calc_addr_width(input int depth);
        if (depth < 2) begin
            return 1;
        end
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo: one synchronous write port, one read port that is
// registered by default or asynchronous when SYNC_FIFO_FWFT_EN is defined.
module sync_fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_WIDTH = calc_addr_width(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic                  i_rclr,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    logic w_unused_rd_ctrl;

    assign o_rdata          = r_mem[i_raddr];
    assign w_unused_rd_ctrl = i_re ^ i_rclr;
`else
    logic [DATA_WIDTH-1:0] r_rdata;

    // Only the output register is cleared; the array itself keeps its contents.
    always_ff @(posedge clk) begin
        if (i_rclr) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;
`endif

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with arbitrary depth, occupancy count, threshold flags, flush
// and sticky error flags. Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter  int DATA_WIDTH    = 8,
    parameter  int FIFO_DEPTH    = 8,
    localparam int ADDR_WIDTH    = calc_addr_width(FIFO_DEPTH),
    parameter  int AFULL_THRESH  = FIFO_DEPTH - 1,
    parameter  int AEMPTY_THRESH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  winc,
    input  logic [DATA_WIDTH-1:0] WR_data,
    input  logic                  rinc,
    output logic [DATA_WIDTH-1:0] RD_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0]   LP_DEPTH  = (ADDR_WIDTH + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0]   LP_AFULL  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0]   LP_AEMPTY = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);
    localparam logic [ADDR_WIDTH:0]   LP_CNT_1  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] LP_LAST   = ADDR_WIDTH'(FIFO_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] LP_PTR_1  = ADDR_WIDTH'(1);

    if (FIFO_DEPTH < 2) begin : g_bad_depth
        $error("sync_fifo: FIFO_DEPTH must be at least 2");
    end
    if (AFULL_THRESH > FIFO_DEPTH) begin : g_bad_afull
        $error("sync_fifo: AFULL_THRESH must not exceed FIFO_DEPTH");
    end
    if (AEMPTY_THRESH >= FIFO_DEPTH) begin : g_bad_aempty
        $error("sync_fifo: AEMPTY_THRESH must be below FIFO_DEPTH");
    end

    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH-1:0] r_rptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [ERR_FLAG_W-1:0] r_err;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_clear;
    logic [DATA_WIDTH-1:0] w_mem_rdata;

    function automatic logic [ADDR_WIDTH-1:0] ptr_next(input logic [ADDR_WIDTH-1:0] p);
        return (p == LP_LAST) ? '0 : p + LP_PTR_1;
    endfunction

    // Acceptance is judged on the pre-edge occupancy, so a simultaneous read
    // never makes room for a write into a full FIFO (and vice versa when empty).
    assign w_full   = (r_count == LP_DEPTH);
    assign w_empty  = (r_count == '0);
    assign w_wr_acc = winc & ~w_full;
    assign w_rd_acc = rinc & ~w_empty;
    assign w_clear  = rst | flush;

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_err   <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= ptr_next(r_wptr);
            end
            if (w_rd_acc) begin
                r_rptr <= ptr_next(r_rptr);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + LP_CNT_1;
                2'b01:   r_count <= r_count - LP_CNT_1;
                default: r_count <= r_count;
            endcase
            if (winc & w_full) begin
                r_err[ERR_OVERFLOW_BIT] <= 1'b1;
            end
            if (rinc & w_empty) begin
                r_err[ERR_UNDERFLOW_BIT] <= 1'b1;
            end
        end
    end

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_acc & ~w_clear),
        .i_waddr (r_wptr),
        .i_wdata (WR_data),
        .i_re    (w_rd_acc & ~w_clear),
        .i_rclr  (w_clear),
        .i_raddr (r_rptr),
        .o_rdata (w_mem_rdata)
    );

`ifdef SYNC_FIFO_FWFT_EN
    assign RD_data  = w_empty ? '0 : w_mem_rdata;
    assign rd_valid = ~w_empty;
`else
    logic r_rd_valid;

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
        end
    end

    assign RD_data  = w_mem_rdata;
    assign rd_valid = r_rd_valid;
`endif

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= LP_AFULL);
    assign almost_empty = (r_count <= LP_AEMPTY);
    assign count        = r_count;
    assign overflow     = r_err[ERR_OVERFLOW_BIT];
    assign underflow    = r_err[ERR_UNDERFLOW_BIT];

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: a depth-8 and a depth-6 instance share one directed stimulus
// stream; a word-index scoreboard predicts every output each cycle.
module tb_sync_fifo;

    localparam int DEP [2] = '{8, 6};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       winc = 1'b0;
    logic       rinc = 1'b0;
    logic [7:0] wd = 8'h00;

    logic [7:0] rd_data [2];
    logic       rd_valid [2];
    logic       full [2];
    logic       empty [2];
    logic       afull [2];
    logic       aempty [2];
    logic [3:0] count [2];
    logic       ovf [2];
    logic       udf [2];

    int nvec  = 0;
    int nfail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    sync_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(8)) u_d8 (
        .clk(clk), .rst(rst), .flush(flush), .winc(winc), .WR_data(wd), .rinc(rinc),
        .RD_data(rd_data[0]), .rd_valid(rd_valid[0]), .full(full[0]), .empty(empty[0]),
        .almost_full(afull[0]), .almost_empty(aempty[0]), .count(count[0]),
        .overflow(ovf[0]), .underflow(udf[0])
    );

    sync_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(6)) u_d6 (
        .clk(clk), .rst(rst), .flush(flush), .winc(winc), .WR_data(wd), .rinc(rinc),
        .RD_data(rd_data[1]), .rd_valid(rd_valid[1]), .full(full[1]), .empty(empty[1]),
        .almost_full(afull[1]), .almost_empty(aempty[1]), .count(count[1]),
        .overflow(ovf[1]), .underflow(udf[1])
    );

    // Scoreboard: every accepted word gets the next write index; occupancy is
    // simply words written minus words read.
    logic [7:0] sb [2][256];
    int         wn [2];
    int         rn [2];
    bit         m_ov [2];
    bit         m_uf [2];
    bit         m_rdv [2];
    logic [7:0] m_rd [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            wn[i] = 0; rn[i] = 0; m_ov[i] = 0; m_uf[i] = 0; m_rdv[i] = 0; m_rd[i] = 8'h00;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int occ;
            bit wa;
            bit ra;
            occ = wn[i] - rn[i];
            if (rst || flush) begin
                wn[i] = 0; rn[i] = 0; m_ov[i] = 0; m_uf[i] = 0; m_rdv[i] = 0; m_rd[i] = 8'h00;
            end else begin
                wa = winc && (occ < DEP[i]);
                ra = rinc && (occ > 0);
                if (winc && !wa) m_ov[i] = 1'b1;
                if (rinc && !ra) m_uf[i] = 1'b1;
                m_rdv[i] = ra;
                if (ra) begin
                    m_rd[i] = sb[i][rn[i] % 256];
                    rn[i]   = rn[i] + 1;
                end
                if (wa) begin
                    sb[i][wn[i] % 256] = wd;
                    wn[i] = wn[i] + 1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                int         occ;
                logic [7:0] e_rd;
                bit         e_rdv;
                occ = wn[i] - rn[i];
`ifdef SYNC_FIFO_FWFT_EN
                e_rdv = (occ > 0);
                e_rd  = (occ > 0) ? sb[i][rn[i] % 256] : 8'h00;
`else
                e_rdv = m_rdv[i];
                e_rd  = m_rd[i];
`endif
                chk($sformatf("d%0d_count", DEP[i]), 32'(count[i]), 32'(occ));
                chk($sformatf("d%0d_full", DEP[i]), 32'(full[i]), 32'(occ == DEP[i]));
                chk($sformatf("d%0d_empty", DEP[i]), 32'(empty[i]), 32'(occ == 0));
                chk($sformatf("d%0d_afull", DEP[i]), 32'(afull[i]), 32'(occ >= DEP[i] - 1));
                chk($sformatf("d%0d_aempty", DEP[i]), 32'(aempty[i]), 32'(occ <= 1));
                chk($sformatf("d%0d_overflow", DEP[i]), 32'(ovf[i]), 32'(m_ov[i]));
                chk($sformatf("d%0d_underflow", DEP[i]), 32'(udf[i]), 32'(m_uf[i]));
                chk($sformatf("d%0d_rd_valid", DEP[i]), 32'(rd_valid[i]), 32'(e_rdv));
                chk($sformatf("d%0d_rd_data", DEP[i]), 32'(rd_data[i]), 32'(e_rd));
            end
        end
    end

    task automatic step(input bit w, input logic [7:0] d, input bit r, input bit f);
        @(negedge clk);
        winc  = w;
        wd    = d;
        rinc  = r;
        flush = f;
        @(posedge clk);
        #1;
    endtask

    // Requests presented alongside rst must be discarded.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; winc = 1'b1; wd = 8'hEE; rinc = 1'b1; flush = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0; winc = 1'b0; rinc = 1'b0;
    endtask

    initial begin
        do_reset();
        chk_en = 1'b1;
        step(0, 8'h00, 0, 0);
        chk("reset_count", 32'(count[0]), 0);
        chk("reset_empty", 32'(empty[0]), 1);
        chk("reset_aempty", 32'(aempty[0]), 1);
        chk("reset_full", 32'(full[0]), 0);
        chk("reset_afull", 32'(afull[0]), 0);
        chk("reset_rd_valid", 32'(rd_valid[0]), 0);
        chk("reset_rd_data", 32'(rd_data[0]), 0);

        for (int k = 1; k <= 8; k++) begin
            step(1, 8'(k), 0, 0);
            if (k == 6) chk("fill_afull_at6", 32'(afull[0]), 0);
            if (k == 7) chk("fill_afull_at7", 32'(afull[0]), 1);
        end
        chk("fill_count8", 32'(count[0]), 8);
        chk("fill_full8", 32'(full[0]), 1);
        chk("fill_d6_full", 32'(full[1]), 1);
        chk("fill_d6_overflow", 32'(ovf[1]), 1);
        for (int k = 1; k <= 8; k++) begin
`ifdef SYNC_FIFO_FWFT_EN
            chk("drain_data", 32'(rd_data[0]), 32'(k));
            step(0, 8'h00, 1, 0);
`else
            step(0, 8'h00, 1, 0);
            chk("drain_data", 32'(rd_data[0]), 32'(k));
            chk("drain_valid", 32'(rd_valid[0]), 1);
`endif
        end
        chk("drain_empty", 32'(empty[0]), 1);
        chk("drain_d8_underflow", 32'(udf[0]), 0);
        chk("drain_d6_underflow", 32'(udf[1]), 1);
        do_reset();

        for (int k = 0; k < 20; k++) begin
            step(1, 8'(8'h10 + k), 0, 0);
`ifdef SYNC_FIFO_FWFT_EN
            chk("wrap_data", 32'(rd_data[1]), 32'(8'h10 + k));
            step(0, 8'h00, 1, 0);
`else
            step(0, 8'h00, 1, 0);
            chk("wrap_data", 32'(rd_data[1]), 32'(8'h10 + k));
`endif
        end
        chk("wrap_empty", 32'(empty[1]), 1);

        for (int k = 0; k < 6; k++) step(1, 8'(8'h30 + k), 0, 0);
        chk("ovf_full", 32'(full[1]), 1);
        step(1, 8'h36, 1, 0);
        chk("ovf_count5", 32'(count[1]), 5);
        chk("ovf_flag", 32'(ovf[1]), 1);
        chk("ovf_d8_count6", 32'(count[0]), 6);
        chk("ovf_d8_flag", 32'(ovf[0]), 0);
`ifndef SYNC_FIFO_FWFT_EN
        chk("ovf_read_data", 32'(rd_data[1]), 32'h30);
`endif

        step(1, 8'h77, 0, 1);
        chk("flush_count", 32'(count[1]), 0);
        chk("flush_empty", 32'(empty[1]), 1);
        chk("flush_overflow", 32'(ovf[1]), 0);
        step(0, 8'h00, 0, 0);
        chk("flush_nowrite", 32'(count[1]), 0);

        step(1, 8'h40, 1, 0);
        chk("udf_count1", 32'(count[1]), 1);
        chk("udf_flag", 32'(udf[1]), 1);
        chk("udf_d8_count1", 32'(count[0]), 1);
        do_reset();
        chk("midreset_count", 32'(count[0]), 0);

        for (int k = 0; k < 4; k++) step(1, 8'(8'h50 + k), 0, 0);
        for (int k = 0; k < 50; k++) begin
`ifdef SYNC_FIFO_FWFT_EN
            chk("stream_data", 32'(rd_data[0]), 32'(8'h50 + k));
            step(1, 8'(8'h54 + k), 1, 0);
`else
            step(1, 8'(8'h54 + k), 1, 0);
            chk("stream_data", 32'(rd_data[0]), 32'(8'h50 + k));
`endif
            chk("stream_count", 32'(count[0]), 4);
        end
        chk("stream_d6_count", 32'(count[1]), 4);

        step(0, 8'h00, 0, 1);
        step(1, 8'hA5, 0, 0);
`ifdef SYNC_FIFO_FWFT_EN
        chk("fwft_data", 32'(rd_data[0]), 32'hA5);
        chk("fwft_valid", 32'(rd_valid[0]), 1);
        step(0, 8'h00, 1, 0);
        chk("fwft_pop_valid", 32'(rd_valid[0]), 0);
`else
        chk("std_nopop_valid", 32'(rd_valid[0]), 0);
        chk("std_nopop_data", 32'(rd_data[0]), 0);
        step(0, 8'h00, 1, 0);
        chk("std_pop_data", 32'(rd_data[0]), 32'hA5);
        chk("std_pop_valid", 32'(rd_valid[0]), 1);
        step(0, 8'h00, 0, 0);
        chk("std_hold_valid", 32'(rd_valid[0]), 0);
        chk("std_hold_data", 32'(rd_data[0]), 32'hA5);
`endif
        step(0, 8'h00, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO; next generation of the team's clock-crossing FIFO for paths where producer and consumer share `clk`. It drops the Gray-pointer synchronisers and adds non-power-of-two depth, programmable almost-full/almost-empty thresholds, an occupancy count, a synchronous flush and sticky overflow/underflow flags. It sits between same-domain blocks, such as UART TX/RX data paths and the register file, wherever rate smoothing is needed.

## Interface
- `DATA_WIDTH`, 8: word width in bits.
- `FIFO_DEPTH`, 8: number of entries; any value ≥ 2, power of two not required.
- `ADDR_WIDTH`, `$clog2(FIFO_DEPTH)`: pointer width; derived, never overridden.
- `AFULL_THRESH`, `FIFO_DEPTH-1`: `almost_full` asserted when count ≥ this value.
- `AEMPTY_THRESH`, 1: `almost_empty` asserted when count ≤ this value.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `flush`  in  1  synchronous clear of contents and error flags.
- `winc`  in  1  write request.
- `WR_data`  in  DATA_WIDTH  write data.
- `rinc`  in  1  read request.
- `RD_data`  out  DATA_WIDTH  read data.
- `rd_valid`  out  1  `RD_data` valid strobe (standard mode only; tied 1 when `!empty` in FWFT).
- `full`, `empty`  out  1  status flags.
- `almost_full`, `almost_empty`  out  1  threshold flags.
- `count`  out  ADDR_WIDTH+1  current occupancy, 0..FIFO_DEPTH.
- `overflow`, `underflow`  out  1  sticky error flags.

## Operation
- Write accepted when `winc & ~full`; read accepted when `rinc & ~empty`. Flags sample the pre-edge state, so:
  - a write while full is rejected even if a read is accepted in the same cycle;
  - a read while empty is rejected even if a write is accepted in the same cycle.
- Pointers `wptr` and `rptr` increment on acceptance and wrap from FIFO_DEPTH-1 to 0.
- `count` is tracked explicitly:
  - +1 on write only;
  - -1 on read only;
  - unchanged when both are accepted.
- `full` = (count == FIFO_DEPTH); `empty` = (count == 0). All status flags are derived from the registered `count`.
- Rejected `winc` sets `overflow`; rejected `rinc` sets `underflow`. Both flags hold until `rst` or `flush`.
- Priority is `rst` > `flush` > `winc`/`rinc`. A `flush` cycle ignores both requests and does not set error flags.
- Thresholds are checked at elaboration: `AFULL_THRESH` ≤ FIFO_DEPTH and `AEMPTY_THRESH` < FIFO_DEPTH. A violation is a `$error`.

## Timing
- Reset/flush values:
  - `count`=0, both pointers 0;
  - `empty`=1, `almost_empty`=1, `full`=0, `almost_full`=0 (1 only if `AFULL_THRESH`=0);
  - `overflow`=0, `underflow`=0, `rd_valid`=0, `RD_data`=0.
  - Memory contents are not cleared.
- Flags and `count` update on the edge that accepts the operation. A write at edge N is visible as `empty`=0 after edge N.
- Standard mode: `RD_data` is registered. Data for a read accepted at edge N appears after edge N, with `rd_valid`=1 for exactly that cycle. `RD_data` holds its value otherwise.
- Full/empty throughput: one write and one read per cycle, sustained indefinitely at any occupancy in 1..FIFO_DEPTH-1.
- `rst` asserted mid-burst takes effect at the next edge; requests in that cycle are discarded.

## Configuration
- `SYNC_FIFO_FWFT_EN` defined (first-word-fall-through):
  - `RD_data` = mem[rptr] combinationally whenever `!empty`; `rinc` pops that word.
  - `rd_valid` = `!empty`.
  - Read latency is 0; a word written at edge N is visible after edge N.
- Not defined: standard registered-read behaviour as in Timing, with 1-cycle latency.

## Structure
- Package `fifo_pkg` holds:
  - a function computing `ADDR_WIDTH` for depth, guarding depth < 2;
  - the error-flag bit positions shared with status registers.
- Sub-module `sync_fifo_mem`: DATA_WIDTH×FIFO_DEPTH array with one write port and one read port, a synchronous write, and a read that is registered or asynchronous depending on `SYNC_FIFO_FWFT_EN`, with no reset on the array.
- Pointer, count, flag and error logic live in the top module.

## Test plan
- Reset, then 8 writes 0x01..0x08 (DEPTH=8): `full`=1 and `count`=8 after the 8th write, `almost_full`=1 from count 7. Then 8 reads return 0x01..0x08 in order and `empty`=1.
- DEPTH=6: 20 interleaved writes/reads of 0x10..0x23 wrap the pointers three times; data returns in order with no loss.
- Fill to full, then assert `winc`+`rinc` together: read accepted, write rejected, `count`=5 and `overflow`=1. At empty, `winc`+`rinc` together: write accepted, read rejected, `count`=1 and `underflow`=1.
- Occupancy 4, sustained simultaneous read/write for 50 cycles: `count` stays 4 and the output sequence matches the input delayed by 4 words.
- At count 5 with `overflow`=1, assert `flush` with `winc`=1: next cycle `count`=0, `empty`=1, `overflow`=0, and nothing is written.
- With `SYNC_FIFO_FWFT_EN`, write 0xA5 into an empty FIFO: `RD_data`=0xA5 and `rd_valid`=1 in the next cycle, before any `rinc`.
